// File: rtl/stb_dcache_drain.sv
// Store-buffer drain controller: writes the oldest committed store to the dcache
// over a req/ack handshake and pops the head entry only once the write is acked.
//
// state    | meaning
// ---------+------------------------------------------------------------
// DR_IDLE  | no write outstanding; samples the buffer head each cycle
// DR_WRITE | request held to the dcache with stable fields until ack
module stb_dcache_drain #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stb_empty,
    input  logic [ADDR_W-1:0] stb_head_addr,
    input  logic [DATA_W-1:0] stb_head_data,
    input  logic [SEL_W-1:0]  stb_head_sel,
    output logic              stb_rd_en,
    output logic              dcache_req,
    output logic              dcache_w_en,
    output logic [ADDR_W-1:0] dcache_addr,
    output logic [DATA_W-1:0] dcache_wdata,
    output logic [SEL_W-1:0]  dcache_sel,
    input  logic              dcache_ack,
    input  logic              load_req_i,
    input  logic              flush_req_i,
    output logic              flush_done_o,
    output logic              drain_busy_o,
    output logic [CNT_W-1:0]  drain_cnt_o
);

    typedef enum logic {
        DR_IDLE  = 1'b0,
        DR_WRITE = 1'b1
    } dr_state_e;

    dr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flush_done_q, flush_done_d;
    logic              start;
    logic              pop;

    // A flush overrides load priority so a fence cannot be starved by loads.
    assign start = !stb_empty && (!load_req_i || flush_req_i);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        pop          = 1'b0;
        flush_done_d = flush_req_i && stb_empty && (state_q == DR_IDLE) && !start;
        case (state_q)
            DR_IDLE: begin
                if (start) begin
                    state_d = DR_WRITE;
                    addr_d  = stb_head_addr;
                    data_d  = stb_head_data;
                    sel_d   = stb_head_sel;
                end
            end
            DR_WRITE: begin
                if (dcache_ack) begin
                    pop     = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = DR_IDLE;
                end
            end
            default: state_d = DR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DR_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            flush_done_q <= flush_done_d;
        end
    end

    // A reset landing on the ack cycle drops the write, so the entry must stay put.
    assign stb_rd_en    = pop && !rst;
    assign dcache_req   = (state_q == DR_WRITE);
    assign dcache_w_en  = dcache_req;
    assign drain_busy_o = dcache_req;
    assign dcache_addr  = addr_q;
    assign dcache_wdata = data_q;
    assign dcache_sel   = sel_q;
    assign flush_done_o = flush_done_q;
    assign drain_cnt_o  = cnt_q;

endmodule

// File: tb/tb_stb_dcache_drain.sv
// Bench for stb_dcache_drain: transaction-level store-buffer model with a
// per-cycle output compare, directed scenarios and a randomized soak.
module tb_stb_dcache_drain;

    localparam int CNT_W = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb_empty;
    logic [31:0] stb_head_addr;
    logic [31:0] stb_head_data;
    logic [3:0]  stb_head_sel;
    logic        stb_rd_en;
    logic        dcache_req;
    logic        dcache_w_en;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_wdata;
    logic [3:0]  dcache_sel;
    logic        dcache_ack;
    logic        load_req_i;
    logic        flush_req_i;
    logic        flush_done_o;
    logic        drain_busy_o;
    logic [CNT_W-1:0] drain_cnt_o;

    stb_dcache_drain #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stb_empty(stb_empty),
        .stb_head_addr(stb_head_addr), .stb_head_data(stb_head_data),
        .stb_head_sel(stb_head_sel), .stb_rd_en(stb_rd_en),
        .dcache_req(dcache_req), .dcache_w_en(dcache_w_en),
        .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_sel(dcache_sel), .dcache_ack(dcache_ack),
        .load_req_i(load_req_i), .flush_req_i(flush_req_i),
        .flush_done_o(flush_done_o), .drain_busy_o(drain_busy_o),
        .drain_cnt_o(drain_cnt_o)
    );

    always #5 clk = ~clk;

    // Store buffer contents double as the model's view of what is pending.
    ent_t q[$];
    bit   m_out = 1'b0;
    ent_t m_ent = '{32'h0, 32'h0, 4'h0};
    int   m_done = 0;
    bit   m_fd = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_req = 0;
    int n_rd  = 0;
    bit chk_en = 1'b0;
    bit rd_prev = 1'b0;
    int cnt_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model advance: one transaction at a time, each store issued on the cycle
    // after it is visible at an idle head, retired on its ack.
    always @(posedge clk) begin
        if (rst) begin
            m_out  = 1'b0;
            m_ent  = '{32'h0, 32'h0, 4'h0};
            m_done = 0;
            m_fd   = 1'b0;
        end else begin
            m_fd = flush_req_i && (q.size() == 0) && !m_out;
            if (m_out) begin
                if (dcache_ack) begin
                    void'(q.pop_front());
                    m_done++;
                    m_out = 1'b0;
                end
            end else if (q.size() > 0 && (!load_req_i || flush_req_i)) begin
                m_out = 1'b1;
                m_ent = q[0];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dcache_req",   dcache_req,   m_out);
            chk("dcache_w_en",  dcache_w_en,  m_out);
            chk("drain_busy",   drain_busy_o, m_out);
            chk("stb_rd_en",    stb_rd_en,    m_out && dcache_ack && !rst);
            chk("dcache_addr",  dcache_addr,  m_ent.a);
            chk("dcache_wdata", dcache_wdata, m_ent.d);
            chk("dcache_sel",   dcache_sel,   m_ent.s);
            chk("flush_done",   flush_done_o, m_fd);
            chk("drain_cnt",    drain_cnt_o,  64'(m_done % (1 << CNT_W)));
            if (rd_prev) cnt_log.push_back(int'(drain_cnt_o));
            rd_prev = (stb_rd_en === 1'b1);
            if (dcache_req === 1'b1) n_req++;
            if (stb_rd_en === 1'b1) n_rd++;
        end
    end

    task automatic step(input bit a);
        dcache_ack = a;
        stb_empty  = (q.size() == 0);
        if (q.size() > 0) begin
            stb_head_addr = q[0].a;
            stb_head_data = q[0].d;
            stb_head_sel  = q[0].s;
        end else begin
            stb_head_addr = 32'h0;
            stb_head_data = 32'h0;
            stb_head_sel  = 4'h0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ent_t e;
        e.a = a;
        e.d = d;
        e.s = s;
        q.push_back(e);
    endtask

    initial begin
        int exp_wrap[5];
        rst = 1'b1;
        load_req_i = 1'b0;
        flush_req_i = 1'b0;
        step(1'b0);
        step(1'b0);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("reset_req", dcache_req, 0);
        chk("reset_cnt", drain_cnt_o, 0);
        chk("reset_addr", dcache_addr, 0);

        // Single store, acked on the third request cycle.
        n_req = 0; n_rd = 0;
        push(32'h1000, 32'hDEADBEEF, 4'hF);
        step(1'b0); step(1'b0); step(1'b0); step(1'b1); step(1'b0);
        chk("single_req_cycles", 64'(n_req), 3);
        chk("single_pops", 64'(n_rd), 1);
        chk("single_cnt", drain_cnt_o, 1);

        // Back-to-back with immediate ack: 5 completions total wraps to 1.
        n_req = 0; n_rd = 0;
        for (int i = 0; i < 4; i++) push(32'h2000 + 32'(i * 4), 32'hA0 + 32'(i), 4'(i + 1));
        for (int i = 0; i < 10; i++) step(1'b1);
        chk("b2b_req_cycles", 64'(n_req), 4);
        chk("b2b_pops", 64'(n_rd), 4);
        chk("b2b_cnt", drain_cnt_o, 1);

        // Load priority, then a load arriving mid-write must not abort it.
        n_req = 0; n_rd = 0;
        load_req_i = 1'b1;
        push(32'h3000, 32'h12345678, 4'h3);
        for (int i = 0; i < 5; i++) step(1'b0);
        chk("load_block_req", 64'(n_req), 0);
        load_req_i = 1'b0;
        step(1'b0);
        load_req_i = 1'b1;
        step(1'b0); step(1'b0); step(1'b1); step(1'b0);
        chk("load_mid_write_pops", 64'(n_rd), 1);
        chk("load_cnt", drain_cnt_o, 2);

        // Flush overrides a held load and reports done once drained.
        n_rd = 0;
        flush_req_i = 1'b1;
        push(32'h4000, 32'hCAFEF00D, 4'hC);
        push(32'h4004, 32'h0BADF00D, 4'h1);
        for (int i = 0; i < 6; i++) step(1'b1);
        chk("flush_pops", 64'(n_rd), 2);
        chk("flush_done_hi", flush_done_o, 1);
        chk("flush_cnt", drain_cnt_o, 0);
        flush_req_i = 1'b0;
        load_req_i = 1'b0;
        step(1'b0);
        chk("flush_done_lo", flush_done_o, 0);

        // Reset while the request is outstanding; stray ack in idle.
        n_rd = 0;
        push(32'h5000, 32'h55AA55AA, 4'h6);
        step(1'b0); step(1'b0);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        load_req_i = 1'b1;
        step(1'b1); step(1'b1);
        chk("rst_pops", 64'(n_rd), 0);
        chk("rst_cnt", drain_cnt_o, 0);
        chk("rst_req", dcache_req, 0);
        chk("rst_entry_kept", 64'(q.size()), 1);
        load_req_i = 1'b0;

        // Five stores from zero: count sequence 1,2,3,0,1.
        cnt_log.delete();
        for (int i = 0; i < 4; i++) push(32'h6000 + 32'(i * 4), 32'hB0 + 32'(i), 4'hF);
        for (int i = 0; i < 12; i++) step(1'b1);
        exp_wrap = '{1, 2, 3, 0, 1};
        chk("wrap_len", 64'(cnt_log.size()), 5);
        for (int i = 0; i < 5; i++)
            if (i < cnt_log.size()) chk("wrap_seq", 64'(cnt_log[i]), 64'(exp_wrap[i]));

        // Randomized soak.
        for (int i = 0; i < 3000; i++) begin
            if (q.size() < 8 && $urandom_range(2) == 0)
                push($urandom, $urandom, 4'($urandom));
            load_req_i = ($urandom_range(3) == 0);
            if ($urandom_range(49) == 0) flush_req_i = !flush_req_i;
            rst = ($urandom_range(299) == 0);
            step(1'($urandom_range(1)));
        end
        rst = 1'b0;
        step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stb_dcache_drain.md
Name: stb_dcache_drain

Overview:
- Drain-side controller of the store buffer.
- Takes the oldest committed store at the store-buffer head and writes it to the data cache / memory over a req/ack handshake.
- Pops the entry only after the cache acknowledges it.
- Sits between store_buffer_datapath (read port) and the dcache write interface; it is the counterpart of the LSU-side write controller that fills the buffer.
- Yields to pending LSU loads and supports a full flush (fence / context switch).

Parameters:
ADDR_W, 32, store address width
DATA_W, 32, store data width
SEL_W, 4, byte-select width (DATA_W/8)
CNT_W, 16, width of completed-store counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
stb_empty  input  1  store buffer has no valid entry
stb_head_addr  input  ADDR_W  address of head entry
stb_head_data  input  DATA_W  data of head entry
stb_head_sel  input  SEL_W  byte selects of head entry
stb_rd_en  output  1  pop head entry (one-cycle pulse)
dcache_req  output  1  write request to dcache
dcache_w_en  output  1  write qualifier, equals dcache_req
dcache_addr  output  ADDR_W  registered request address
dcache_wdata  output  DATA_W  registered request data
dcache_sel  output  SEL_W  registered byte selects
dcache_ack  input  1  dcache accepted/completed the write
load_req_i  input  1  LSU load pending; drain must not start
flush_req_i  input  1  level: drain buffer completely
flush_done_o  output  1  buffer empty and drain idle under flush
drain_busy_o  output  1  write transaction outstanding
drain_cnt_o  output  CNT_W  completed-store count, wraps

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high, sampled on posedge clk.
- Reset values:
  - All outputs 0.
  - State = DR_IDLE.
  - drain_cnt_o = 0.
- DR_IDLE:
  - Start condition: !stb_empty && (!load_req_i || flush_req_i).
  - When the start condition holds, at the edge: latch stb_head_addr, stb_head_data, stb_head_sel into the dcache_* registers, set dcache_req=1, go to DR_WRITE.
  - Otherwise stay in DR_IDLE; dcache_req stays 0.
- DR_WRITE:
  - dcache_req, dcache_w_en and drain_busy_o are 1.
  - Address, data and sel are held stable until acknowledged.
  - While dcache_ack=0: stay in DR_WRITE. No timeout.
  - When dcache_ack=1 (Mealy, same cycle): stb_rd_en=1 for exactly that cycle.
  - At the following edge: dcache_req←0, drain_cnt_o←drain_cnt_o+1 (mod 2^CNT_W), go to DR_IDLE.
  - load_req_i is ignored in DR_WRITE; a started write is never aborted.
- Latency and throughput:
  - First dcache_req is one cycle after stb_empty falls while in DR_IDLE.
  - Minimum spacing is 2 cycles per store: one DR_IDLE cycle samples the new head after the pop edge.
- dcache_ack in DR_IDLE is ignored: no pop, no count.
- stb_rd_en is never asserted outside the ack cycle of DR_WRITE.
- Flush:
  - While flush_req_i=1, load priority is overridden.
  - flush_done_o is registered: at each edge flush_done_o ← flush_req_i && stb_empty && state==DR_IDLE && !start condition.
  - flush_done_o drops the cycle after flush_req_i falls or an entry arrives.
- Simultaneous stb_empty falling and load_req_i=1 in DR_IDLE (no flush): wait; start once load_req_i=0.
- Reset mid-operation (rst in DR_WRITE): request is dropped at that edge, entry is not popped, drain_cnt_o clears.
- drain_cnt_o wraps from 2^CNT_W−1 to 0 silently.

Test Plan:
- Single store: buffer holds addr=0x1000, data=0xDEADBEEF, sel=0xF; dcache_ack 3 cycles after req.
  -> dcache_req high 3 cycles with stable fields; stb_rd_en pulses once in the ack cycle; drain_cnt_o=1; back in DR_IDLE.
- Back-to-back: 4 entries, ack immediate.
  -> 4 requests spaced 2 cycles; exactly 4 stb_rd_en pulses; entries issued in FIFO order; drain_cnt_o=4; stb_empty then no further req.
- Load priority: entry pending with load_req_i=1 for 5 cycles.
  -> no dcache_req during those cycles; req rises 1 cycle after load_req_i falls.
  -> load_req_i raised during DR_WRITE does not abort; the write completes.
- Flush: 2 entries, load_req_i=1 and flush_req_i=1 held.
  -> both entries drain despite the load; flush_done_o=1 one cycle after the final return to idle with stb_empty; flush_done_o=0 the cycle after flush_req_i drops.
- Reset mid-write: assert rst while dcache_req=1 and ack not yet seen.
  -> next cycle all outputs 0, no stb_rd_en pulse, drain_cnt_o=0; a stray ack while in DR_IDLE causes no pop.
- Counter wrap: CNT_W=2, 5 stores.
  -> drain_cnt_o sequence 1,2,3,0,1.
